// File: rtl/multiplier_control_tt_seq.sv
// Control FSM with taint tracking for a shift-add sequential multiplier, bit-index counter based.
// Define MULT_CTRL_CONST_TIME_EN to visit ADD for every bit, giving a data-independent latency.
module multiplier_control_tt_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             start_t,
    input  logic [WIDTH-1:0] multiplier_reg,
    input  logic [WIDTH-1:0] multiplier_reg_t,
    output logic             rs_load,
    output logic             rs_load_t,
    output logic             rs_clear,
    output logic             rs_clear_t,
    output logic             rs_shr,
    output logic             rs_shr_t,
    output logic             mr_ld,
    output logic             mr_ld_t,
    output logic             md_ld,
    output logic             md_ld_t,
    output logic             busy,
    output logic             busy_t,
    output logic             product_done,
    output logic             product_done_t
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ADD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt, idx_inc;
    logic             ctrl_t, ctrl_t_nxt;
    logic             taint;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            idx    <= '0;
            ctrl_t <= 1'b0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            ctrl_t <= ctrl_t_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        idx_nxt        = idx;
        ctrl_t_nxt     = ctrl_t;
        idx_inc        = idx + IDX_W'(1);
        taint          = ctrl_t & (state != S_IDLE);

        rs_load        = 1'b0;
        rs_clear       = 1'b0;
        rs_shr         = 1'b0;
        mr_ld          = 1'b0;
        md_ld          = 1'b0;
        busy           = (state != S_IDLE);
        product_done   = 1'b0;
        rs_load_t      = taint;
        rs_clear_t     = taint;
        rs_shr_t       = taint;
        mr_ld_t        = taint;
        md_ld_t        = taint;
        busy_t         = taint;
        product_done_t = taint;

        case (state)
            S_IDLE: begin
                // The branch depends on start, so its taint is captured even when start is low.
                ctrl_t_nxt = start_t;
                if (start) state_nxt = S_INIT;
            end
            S_INIT: begin
                md_ld    = 1'b1;
                mr_ld    = 1'b1;
                rs_clear = 1'b1;
                idx_nxt  = '0;
`ifdef MULT_CTRL_CONST_TIME_EN
                state_nxt = S_ADD;
`else
                state_nxt  = multiplier_reg[0] ? S_ADD : S_SHIFT;
                ctrl_t_nxt = ctrl_t | multiplier_reg_t[0];
`endif
            end
            S_ADD: begin
`ifdef MULT_CTRL_CONST_TIME_EN
                // Only the strobe value depends on the data; the state sequence does not.
                rs_load   = multiplier_reg[idx];
                rs_load_t = ctrl_t | multiplier_reg_t[idx];
`else
                rs_load   = 1'b1;
`endif
                state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                rs_shr = 1'b1;
                if (idx == IDX_LAST) begin
                    state_nxt = S_DONE;
                end else begin
                    idx_nxt = idx_inc;
`ifdef MULT_CTRL_CONST_TIME_EN
                    state_nxt = S_ADD;
`else
                    state_nxt  = multiplier_reg[idx_inc] ? S_ADD : S_SHIFT;
                    ctrl_t_nxt = ctrl_t | multiplier_reg_t[idx_inc];
`endif
                end
            end
            S_DONE: begin
                product_done = 1'b1;
                state_nxt    = S_IDLE;
                ctrl_t_nxt   = 1'b0;
            end
            default: begin
                state_nxt  = S_IDLE;
                ctrl_t_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_multiplier_control_tt_seq.sv
// Self-checking bench for multiplier_control_tt_seq: vector table, corner sequences, random ops vs trace model.
module tb_multiplier_control_tt_seq;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         start_t;
    logic [W-1:0] multiplier_reg;
    logic [W-1:0] multiplier_reg_t;
    logic rs_load, rs_load_t, rs_clear, rs_clear_t, rs_shr, rs_shr_t;
    logic mr_ld, mr_ld_t, md_ld, md_ld_t, busy, busy_t, product_done, product_done_t;

    multiplier_control_tt_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_t(start_t),
        .multiplier_reg(multiplier_reg), .multiplier_reg_t(multiplier_reg_t),
        .rs_load(rs_load), .rs_load_t(rs_load_t),
        .rs_clear(rs_clear), .rs_clear_t(rs_clear_t),
        .rs_shr(rs_shr), .rs_shr_t(rs_shr_t),
        .mr_ld(mr_ld), .mr_ld_t(mr_ld_t),
        .md_ld(md_ld), .md_ld_t(md_ld_t),
        .busy(busy), .busy_t(busy_t),
        .product_done(product_done), .product_done_t(product_done_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe order: rs_load rs_clear rs_shr mr_ld md_ld busy product_done, then the same taints.
    logic [13:0] dut_out;
    assign dut_out = {rs_load, rs_clear, rs_shr, mr_ld, md_ld, busy, product_done,
                      rs_load_t, rs_clear_t, rs_shr_t, mr_ld_t, md_ld_t, busy_t, product_done_t};

    localparam logic [6:0] P_INIT  = 7'b0101110;
    localparam logic [6:0] P_ADD   = 7'b1000010;
    localparam logic [6:0] P_SHIFT = 7'b0010010;
    localparam logic [6:0] P_DONE  = 7'b0000011;

    int checks = 0;
    int errors = 0;
    logic [13:0] exp_q[$];

    typedef struct {
        logic [W-1:0] mr;
        logic [W-1:0] mr_t;
        logic         st_t;
        int           lat;
    } vec_t;
    vec_t tbl[6];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int lat_ref(input logic [W-1:0] mr);
`ifdef MULT_CTRL_CONST_TIME_EN
        return 2 + 2 * W;
`else
        return 2 + W + $countones(mr);
`endif
    endfunction

    // Expected per-cycle outputs from INIT through DONE, derived from the bit-serial algorithm.
    task automatic build_trace(input logic [W-1:0] mr, input logic [W-1:0] mr_t, input logic st_t);
        logic t;
        t = st_t;
        exp_q.delete();
        exp_q.push_back({P_INIT, {7{t}}});
        for (int i = 0; i < W; i++) begin
`ifdef MULT_CTRL_CONST_TIME_EN
            exp_q.push_back({mr[i], P_ADD[5:0], t | mr_t[i], {6{t}}});
`else
            t = t | mr_t[i];
            if (mr[i]) exp_q.push_back({P_ADD, {7{t}}});
`endif
            exp_q.push_back({P_SHIFT, {7{t}}});
        end
        exp_q.push_back({P_DONE, {7{t}}});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [W-1:0] mr, input logic [W-1:0] mr_t, input logic st_t,
                          input int exp_lat, input string nm);
        int done_cyc;
        build_trace(mr, mr_t, st_t);
        multiplier_reg   = mr;
        multiplier_reg_t = mr_t;
        start            = 1'b1;
        start_t          = st_t;
        step();
        start   = 1'b0;
        start_t = 1'b0;
        done_cyc = -1;
        for (int k = 0; k < exp_q.size(); k++) begin
            check($sformatf("%s_cyc%0d", nm, k + 1), 64'(dut_out), 64'(exp_q[k]));
            if (product_done && done_cyc < 0) done_cyc = k + 1;
            step();
        end
        check({nm, "_idle_after"}, 64'(dut_out), 64'd0);
        check({nm, "_latency"}, 64'(done_cyc), 64'(exp_lat));
    endtask

    initial begin
        int exp_lat;
        int wait_cnt;
        logic seen;
        logic [W-1:0] rmr, rmr_t;
        logic rst_t;

        tbl[0] = '{4'b1011, 4'b0000, 1'b0, 9};
        tbl[1] = '{4'b0000, 4'b0000, 1'b0, 6};
        tbl[2] = '{4'b1011, 4'b0100, 1'b0, 9};
        tbl[3] = '{4'b1111, 4'b0000, 1'b1, 10};
        tbl[4] = '{4'b1000, 4'b0001, 1'b0, 7};
        tbl[5] = '{4'b0110, 4'b1010, 1'b0, 8};

        rst_n = 1'b0;
        start = 1'b0;
        start_t = 1'b1;
        multiplier_reg = '1;
        multiplier_reg_t = '1;
        step();
        step();
        check("reset_outputs", 64'(dut_out), 64'd0);
        start_t = 1'b0;
        rst_n = 1'b1;
        step();
        check("idle_after_reset", 64'(dut_out), 64'd0);

        for (int i = 0; i < 6; i++) begin
`ifdef MULT_CTRL_CONST_TIME_EN
            exp_lat = 2 + 2 * W;
`else
            exp_lat = tbl[i].lat;
`endif
            run_op(tbl[i].mr, tbl[i].mr_t, tbl[i].st_t, exp_lat, $sformatf("vec%0d", i));
        end

        // Tainted start with start low: stays idle, taint never visible.
        start = 1'b0;
        start_t = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("taint_idle%0d", i), 64'(dut_out), 64'd0);
        end
        run_op(4'b0110, 4'b0000, 1'b0, lat_ref(4'b0110), "clean_after_taint");

        // Asynchronous reset in cycle 4 of an operation.
        multiplier_reg = 4'b1011;
        multiplier_reg_t = 4'b0000;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        check("pre_reset_busy", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 64'(dut_out), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (product_done) seen = 1'b1;
        end
        check("no_done_during_reset", 64'(seen), 64'd0);
        rst_n = 1'b1;
        step();
        run_op(4'b1011, 4'b0000, 1'b0, lat_ref(4'b1011), "after_reset");

        // Start held high: ignored while busy, restarts after one idle cycle past DONE.
        multiplier_reg = 4'b0001;
        multiplier_reg_t = 4'b0000;
        start = 1'b1;
        step();
        wait_cnt = 1;
        while (!product_done && wait_cnt < 40) begin
            step();
            wait_cnt++;
        end
        check("held_latency", 64'(wait_cnt), 64'(lat_ref(4'b0001)));
        step();
        check("held_idle_gap_busy", 64'(busy), 64'd0);
        step();
        check("held_restart_init", 64'(dut_out), 64'({P_INIT, 7'b0}));
        start = 1'b0;
        wait_cnt = 0;
        while (!product_done && wait_cnt < 40) begin
            step();
            wait_cnt++;
        end
        check("held_second_done", 64'(product_done), 64'd1);
        step();
        check("held_back_idle", 64'(dut_out), 64'd0);

        // Random operations against the trace model.
        for (int n = 0; n < 40; n++) begin
            rmr = W'($urandom);
            rmr_t = ($urandom_range(0, 2) == 0) ? W'($urandom) : '0;
            rst_t = ($urandom_range(0, 4) == 0);
            run_op(rmr, rmr_t, rst_t, lat_ref(rmr), $sformatf("rand%0d", n));
            if ($urandom_range(0, 1) == 1) step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
